// File: rtl/unidade_controle_jogo.sv
// Control unit for the memory game: a Moore FSM that sequences the datapath
// counters, the play register and the comparator through rounds of plays.
// Every output, including the debug state code, is registered.
module unidade_controle_jogo #(
    parameter bit TIMEOUT_EN = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       jogar,
    input  logic       tem_jogada,
    input  logic       jogada_correta,
    input  logic       enderecoIgualRodada,
    input  logic       fimR,
    input  logic       timeout,
    output logic       zeraE,
    output logic       contaE,
    output logic       zeraR,
    output logic       contaR,
    output logic       registraR,
    output logic       zeraT,
    output logic       contaT,
    output logic       ganhou,
    output logic       perdeu,
    output logic       pronto,
    output logic       db_timeout,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        StInicial       = 4'h0,
        StPreparacao    = 4'h1,
        StInicioRodada  = 4'h2,
        StEsperaJogada  = 4'h3,
        StRegistra      = 4'h4,
        StComparacao    = 4'h5,
        StProximaJogada = 4'h6,
        StProximaRodada = 4'h7,
        StFimAcertou    = 4'hA,
        StFimTimeout    = 4'hD,
        StFimErrou      = 4'hE
    } estado_t;

    estado_t estado_q, estado_d;

    // Next-state selection; unused encodings fall back to the idle state
    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            StInicial:       estado_d = jogar ? StPreparacao : StInicial;
            StPreparacao:    estado_d = StInicioRodada;
            StInicioRodada:  estado_d = StEsperaJogada;
            StEsperaJogada: begin
                // Timeout has priority over a play arriving in the same cycle
                if (timeout && TIMEOUT_EN) begin
                    estado_d = StFimTimeout;
                end else if (tem_jogada) begin
                    estado_d = StRegistra;
                end else begin
                    estado_d = StEsperaJogada;
                end
            end
            // One wait cycle so the comparator sees the freshly loaded play
            StRegistra:      estado_d = StComparacao;
            StComparacao: begin
                if (!jogada_correta) begin
                    estado_d = StFimErrou;
                end else if (enderecoIgualRodada && fimR) begin
                    estado_d = StFimAcertou;
                end else if (enderecoIgualRodada) begin
                    estado_d = StProximaRodada;
                end else begin
                    estado_d = StProximaJogada;
                end
            end
            StProximaJogada: estado_d = StEsperaJogada;
            StProximaRodada: estado_d = StInicioRodada;
            StFimAcertou,
            StFimErrou,
            StFimTimeout:    estado_d = jogar ? StPreparacao : estado_q;
            default:         estado_d = StInicial;
        endcase
    end

    // State register; outputs are decoded from the next state so they line up with it
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q   <= StInicial;
            zeraE      <= 1'b0;
            contaE     <= 1'b0;
            zeraR      <= 1'b0;
            contaR     <= 1'b0;
            registraR  <= 1'b0;
            zeraT      <= 1'b0;
            contaT     <= 1'b0;
            ganhou     <= 1'b0;
            perdeu     <= 1'b0;
            pronto     <= 1'b0;
            db_timeout <= 1'b0;
            db_estado  <= 4'h0;
        end else begin
            estado_q   <= estado_d;
            zeraE      <= (estado_d == StPreparacao) || (estado_d == StInicioRodada);
            contaE     <= (estado_d == StProximaJogada);
            zeraR      <= (estado_d == StPreparacao);
            contaR     <= (estado_d == StProximaRodada);
            registraR  <= (estado_d == StRegistra);
            zeraT      <= (estado_d == StPreparacao) || (estado_d == StInicioRodada)
                          || (estado_d == StProximaJogada);
            contaT     <= (estado_d == StEsperaJogada);
            ganhou     <= (estado_d == StFimAcertou);
            perdeu     <= (estado_d == StFimErrou) || (estado_d == StFimTimeout);
            pronto     <= (estado_d == StFimAcertou) || (estado_d == StFimErrou)
                          || (estado_d == StFimTimeout);
            db_timeout <= (estado_d == StFimTimeout);
            db_estado  <= estado_d;
        end
    end

endmodule

// File: tb/tb_unidade_controle_jogo.sv
// Self-checking bench for the memory-game control unit: a game-level model
// checked every cycle, plus literal checkpoints at key points of each game.
module tb_unidade_controle_jogo;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       jogar = 1'b0;
    logic       tem_jogada = 1'b0;
    logic       jogada_correta = 1'b0;
    logic       enderecoIgualRodada = 1'b0;
    logic       fimR = 1'b0;
    logic       timeout = 1'b0;
    logic       zeraE, contaE, zeraR, contaR, registraR, zeraT, contaT;
    logic       ganhou, perdeu, pronto, db_timeout;
    logic [3:0] db_estado;

    int errors = 0;
    int checks = 0;
    int n_reg = 0;
    int n_contaR = 0;

    // Model: game phase as its debug code
    int m_code = 0;
    bit m_valid = 1'b0;

    unidade_controle_jogo dut (
        .clock(clock), .reset(reset), .jogar(jogar), .tem_jogada(tem_jogada),
        .jogada_correta(jogada_correta), .enderecoIgualRodada(enderecoIgualRodada),
        .fimR(fimR), .timeout(timeout), .zeraE(zeraE), .contaE(contaE), .zeraR(zeraR),
        .contaR(contaR), .registraR(registraR), .zeraT(zeraT), .contaT(contaT),
        .ganhou(ganhou), .perdeu(perdeu), .pronto(pronto), .db_timeout(db_timeout),
        .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Game-level model advanced on each rising edge
    always @(posedge clock) begin
        bit game_over;
        game_over = (m_code == 'hA) || (m_code == 'hE) || (m_code == 'hD);
        if (reset) begin
            m_code = 0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            if (m_code == 0 || game_over) begin
                if (jogar) m_code = 1;
            end else if (m_code == 1) m_code = 2;
            else if (m_code == 2) m_code = 3;
            else if (m_code == 3) begin
                if (timeout) m_code = 'hD;
                else if (tem_jogada) m_code = 4;
            end else if (m_code == 4) m_code = 5;
            else if (m_code == 5) begin
                if (!jogada_correta) m_code = 'hE;
                else if (enderecoIgualRodada) m_code = fimR ? 'hA : 7;
                else m_code = 6;
            end else if (m_code == 6) m_code = 3;
            else if (m_code == 7) m_code = 2;
            else m_code = 0;
        end
    end

    // Compare every cycle once reset has been applied
    always @(negedge clock) begin
        if (m_valid) begin
            chk("db_estado", db_estado, m_code);
            chk("zeraE", zeraE, (m_code == 1 || m_code == 2));
            chk("zeraR", zeraR, (m_code == 1));
            chk("zeraT", zeraT, (m_code == 1 || m_code == 2 || m_code == 6));
            chk("contaE", contaE, (m_code == 6));
            chk("contaR", contaR, (m_code == 7));
            chk("contaT", contaT, (m_code == 3));
            chk("registraR", registraR, (m_code == 4));
            chk("ganhou", ganhou, (m_code == 'hA));
            chk("perdeu", perdeu, (m_code == 'hE || m_code == 'hD));
            chk("pronto", pronto, (m_code == 'hA || m_code == 'hE || m_code == 'hD));
            chk("db_timeout", db_timeout, (m_code == 'hD));
            chk("overlapE", zeraE & contaE, 0);
            chk("overlapR", zeraR & contaR, 0);
            chk("overlapT", zeraT & contaT, 0);
            n_reg += registraR;
            n_contaR += contaR;
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // One play from espera_jogada, returning to espera_jogada unless the game ends
    task automatic play(input bit ok, input bit last, input bit fim);
        cyc();
        jogada_correta = ok;
        enderecoIgualRodada = last;
        fimR = fim;
        tem_jogada = 1'b1;
        cyc();
        tem_jogada = 1'b0;
        cyc();
        cyc();
        if (ok && !(last && fim)) begin
            if (last) cyc(2);
            else cyc();
        end
        jogada_correta = 1'b0;
        enderecoIgualRodada = 1'b0;
        fimR = 1'b0;
    endtask

    task automatic restart();
        jogar = 1'b1;
        cyc();
        chk("restart_prep", db_estado, 1);
        jogar = 1'b0;
        cyc();
        chk("restart_inicio", db_estado, 2);
        cyc();
        chk("restart_espera", db_estado, 3);
        chk("restart_pronto", pronto, 0);
        chk("restart_perdeu", perdeu, 0);
        chk("restart_ganhou", ganhou, 0);
    endtask

    initial begin
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("reset_estado", db_estado, 0);
        chk("reset_pronto", pronto, 0);
        cyc(10);
        chk("idle_estado", db_estado, 0);

        jogar = 1'b1;
        cyc();
        chk("prep_estado", db_estado, 1);
        chk("prep_zeraE", zeraE, 1);
        chk("prep_zeraR", zeraR, 1);
        chk("prep_zeraT", zeraT, 1);
        cyc();
        chk("inicio_estado", db_estado, 2);
        cyc();
        chk("espera_estado", db_estado, 3);
        cyc(2);
        chk("jogar_ignored", db_estado, 3);
        chk("espera_pronto", pronto, 0);
        jogar = 1'b0;

        // Full winning game
        n_reg = 0;
        n_contaR = 0;
        for (int r = 0; r < 16; r++)
            for (int j = 0; j <= r; j++)
                play(1'b1, j == r, r == 15);
        chk("win_estado", db_estado, 'hA);
        chk("win_ganhou", ganhou, 1);
        chk("win_pronto", pronto, 1);
        chk("win_perdeu", perdeu, 0);
        chk("win_registraR", n_reg, 136);
        chk("win_contaR", n_contaR, 15);

        // Wrong play in round 4
        restart();
        n_contaR = 0;
        for (int r = 0; r < 4; r++)
            for (int j = 0; j <= r; j++)
                play(1'b1, j == r, 1'b0);
        play(1'b1, 1'b0, 1'b0);
        play(1'b1, 1'b0, 1'b0);
        play(1'b0, 1'b0, 1'b0);
        chk("err_estado", db_estado, 'hE);
        chk("err_perdeu", perdeu, 1);
        chk("err_pronto", pronto, 1);
        chk("err_ganhou", ganhou, 0);
        chk("err_contaR", n_contaR, 4);

        // Timeout with no play
        restart();
        cyc(3);
        timeout = 1'b1;
        cyc();
        timeout = 1'b0;
        chk("to_estado", db_estado, 'hD);
        chk("to_perdeu", perdeu, 1);
        chk("to_db_timeout", db_timeout, 1);
        chk("to_pronto", pronto, 1);

        // Timeout and play in the same cycle
        restart();
        timeout = 1'b1;
        tem_jogada = 1'b1;
        cyc();
        timeout = 1'b0;
        tem_jogada = 1'b0;
        chk("to_both_estado", db_estado, 'hD);
        chk("to_both_registraR", registraR, 0);

        // Reset mid-round
        restart();
        for (int r = 0; r < 2; r++)
            for (int j = 0; j <= r; j++)
                play(1'b1, j == r, 1'b0);
        play(1'b1, 1'b0, 1'b0);
        chk("mid_estado", db_estado, 3);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("mid_reset_estado", db_estado, 0);
        chk("mid_reset_contaT", contaT, 0);
        chk("mid_reset_zeraE", zeraE, 0);
        cyc(2);
        chk("mid_reset_idle", db_estado, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
